// File: rtl/bcd_convert_ctrl_if.sv
// Handshake bundle between a binary source and the BCD conversion controller:
// start/bin_in request, busy/done status, and five registered BCD digits.
interface bcd_convert_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] bin_in;
  logic             busy;
  logic             done;
  logic [3:0]       BCD0;
  logic [3:0]       BCD1;
  logic [3:0]       BCD2;
  logic [3:0]       BCD3;
  logic [3:0]       BCD4;

  modport master (
    output start, bin_in,
    input  busy, done, BCD0, BCD1, BCD2, BCD3, BCD4
  );

  modport slave (
    input  start, bin_in,
    output busy, done, BCD0, BCD1, BCD2, BCD3, BCD4
  );
endinterface

// File: rtl/bcd_convert_ctrl.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) with a
// start/busy/done handshake and five held BCD output digits.
module bcd_convert_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  bcd_convert_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [19:0]          scratch_q, scratch_d;
  logic [4:0]           bitcnt_q, bitcnt_d;
  logic [19:0]          bcd_q, bcd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [19:0]          scratch_adj_s;
  logic [WIDTH+19:0]    shifted_s;

  // Nibble >= 5 gets +3; operand is at most 9 so the sum never leaves the nibble.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    logic [3:0] res;
    if (nib >= 4'd5) begin
      res = nib + 4'd3;
    end else begin
      res = nib;
    end
    return res;
  endfunction

  // Parallel add-3 correction followed by the combined one-bit left shift.
  always_comb begin
    scratch_adj_s = 20'd0;
    for (int i = 0; i < 5; i++) begin
      scratch_adj_s[4*i +: 4] = add3(scratch_q[4*i +: 4]);
    end
    shifted_s = {scratch_adj_s, shift_q} << 5'd1;
  end

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    bitcnt_d  = bitcnt_q;
    bcd_d     = bcd_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          shift_d   = bus.bin_in;
          scratch_d = 20'd0;
          bitcnt_d  = 5'(WIDTH);
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        busy_d    = 1'b1;
        scratch_d = shifted_s[WIDTH+19:WIDTH];
        shift_d   = shifted_s[WIDTH-1:0];
        bitcnt_d  = bitcnt_q - 5'd1;
        if (bitcnt_q == 5'd1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        // Digits only ever change here, so the display never sees partial sums.
        bcd_d   = scratch_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= 20'd0;
      bitcnt_q  <= 5'd0;
      bcd_q     <= 20'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      bitcnt_q  <= bitcnt_d;
      bcd_q     <= bcd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.BCD0 = bcd_q[3:0];
  assign bus.BCD1 = bcd_q[7:4];
  assign bus.BCD2 = bcd_q[11:8];
  assign bus.BCD3 = bcd_q[15:12];
  assign bus.BCD4 = bcd_q[19:16];

endmodule

// File: tb/tb_bcd_convert_ctrl.sv
// Directed bench for bcd_convert_ctrl: latency, digits, handshake, reset abort
// and back-to-back operation, all against hand-computed values.
module tb_bcd_convert_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  bcd_convert_ctrl_if #(.WIDTH(16)) bus ();

  bcd_convert_ctrl #(.WIDTH(16)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  logic [19:0] digits_s;
  assign digits_s = {bus.BCD4, bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start; returns at the negedge right after the accepting edge.
  task automatic start_conv(input logic [15:0] v);
    @(negedge clk);
    bus.bin_in = v;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; waits for done and checks
  // latency, busy behaviour, digit hold and the final digits.
  task automatic wait_done(input string tag, input logic [19:0] exp_digits);
    int          k;
    logic        busy_ok;
    logic        hold_ok;
    logic [19:0] held;
    k       = 0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    held    = digits_s;
    check_val({tag, "_busy0"}, 32'(bus.busy), 32'd1);
    while (!bus.done && k < 40) begin
      if (!bus.busy) busy_ok = 1'b0;
      if (digits_s !== held) hold_ok = 1'b0;
      @(negedge clk);
      k++;
    end
    check_val({tag, "_latency"}, 32'(k), 32'd17);
    check_val({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
    check_val({tag, "_hold"}, 32'(hold_ok), 32'd1);
    check_val({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_digits"}, 32'(digits_s), 32'(exp_digits));
  endtask

  initial begin
    int n_done;
    int k;
    int t1;
    int t2;
    logic [19:0] d1;
    logic [19:0] d2;
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = 16'd0;

    // 1: reset held three clocks
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_digits", 32'(digits_s), 32'h00000);

    // 2: zero
    start_conv(16'd0);
    wait_done("zero", 20'h00000);
    @(negedge clk);
    check_val("zero_done_pulse", 32'(bus.done), 32'd0);

    // 3: full scale then a mid value
    start_conv(16'd65535);
    wait_done("max", 20'h65535);
    start_conv(16'd1234);
    wait_done("v1234", 20'h01234);

    // 4: start during busy is ignored; bin_in change after acceptance is ignored
    start_conv(16'd9999);
    repeat (3) @(negedge clk);
    bus.bin_in = 16'd5;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check_val("ignore_done_count", 32'(n_done), 32'd1);
    check_val("ignore_digits", 32'(digits_s), 32'h09999);

    // 5: reset mid-conversion aborts without a done pulse
    start_conv(16'd40000);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("abort_busy", 32'(bus.busy), 32'd0);
    check_val("abort_digits", 32'(digits_s), 32'h00000);
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check_val("abort_done_count", 32'(n_done), 32'd0);
    start_conv(16'd7);
    wait_done("seven", 20'h00007);

    // 6: start held high, two back-to-back conversions
    @(negedge clk);
    bus.bin_in = 16'd10000;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.bin_in = 16'd59999;
    k  = 0;
    t1 = -1;
    t2 = -1;
    d1 = 20'd0;
    d2 = 20'd0;
    while (t2 < 0 && k < 60) begin
      @(negedge clk);
      k++;
      if (bus.done) begin
        if (t1 < 0) begin
          t1 = k;
          d1 = digits_s;
        end else begin
          t2 = k;
          d2 = digits_s;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check_val("b2b_first_latency", 32'(t1), 32'd17);
    check_val("b2b_period", 32'(t2 - t1), 32'd18);
    check_val("b2b_digits1", 32'(d1), 32'h10000);
    check_val("b2b_digits2", 32'(d2), 32'h59999);
    n_done = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check_val("b2b_stop", 32'(n_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
